// File: rtl/mem_responder.sv
// Single-port word RAM behind a req/ack handshake with a fixed number of wait states.
// Out-of-range addresses complete normally but flag err and never touch the RAM.
module mem_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_ack;
  logic              r_err;
  logic              r_busy;
  logic [31:0]       r_mem [DEPTH];
  logic              w_in_range;
  logic              w_mem_we;

  assign w_in_range = (32'(r_addr) < 32'(DEPTH));
  // Gating with clr keeps a write that coincides with reset from committing.
  assign w_mem_we   = (r_state == S_ACCESS) && r_we && w_in_range && !clr;

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == CNT_W'(1)) w_next = S_ACCESS;
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
          end
        end
        S_WAIT: r_cnt <= r_cnt - 1'b1;
        S_ACCESS: begin
          r_ack  <= 1'b1;
          r_busy <= 1'b0;
          if (!w_in_range) begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end else if (!r_we) begin
            r_rdata <= r_mem[r_addr];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responder instances (2 wait states, 0 wait states, DEPTH=500)
// driven by a single linear stimulus sequence with hand-computed expectations.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req   [3];
  logic        we    [3];
  logic [8:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .clr(clr), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .clr(clr), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));

  mem_responder #(.DEPTH(500), .ADDR_W(9), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .clr(clr), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; lat counts cycles from the one after capture to the ack cycle.
  task automatic txn(input int k, input logic w, input logic [8:0] a, input logic [31:0] d,
                     input int lat, input logic [31:0] exp_rd, input logic exp_err,
                     input logic chk_hold, input logic [31:0] hold_val, input string tag);
    int n;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    @(negedge clk);
    req[k] = 1'b0;
    check({tag, " busy_set"}, 32'(busy[k]), 32'd1);
    n = 0;
    while (!ack[k] && n < 20) begin
      if (chk_hold) check({tag, " rdata_hold"}, rdata[k], hold_val);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " rdata"}, rdata[k], exp_rd);
    check({tag, " err"}, 32'(err[k]), 32'(exp_err));
    check({tag, " busy_clr"}, 32'(busy[k]), 32'd0);
    @(negedge clk);
    check({tag, " ack_drop"}, 32'(ack[k]), 32'd0);
    check({tag, " err_drop"}, 32'(err[k]), 32'd0);
  endtask

  initial begin
    int n;
    int acks;
    logic [31:0] seen;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d rdata", k), rdata[k], 32'd0);
      check($sformatf("reset%0d ack", k), 32'(ack[k]), 32'd0);
      check($sformatf("reset%0d err", k), 32'(err[k]), 32'd0);
      check($sformatf("reset%0d busy", k), 32'(busy[k]), 32'd0);
    end
    clr = 1'b0;

    // 2 wait states: write then read back
    txn(0, 1'b1, 9'd5, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1'b0, 32'h0, "t1_wr5");
    txn(0, 1'b0, 9'd5, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "t1_rd5");

    // zero wait states
    txn(1, 1'b1, 9'd5, 32'hDEADBEEF, 1, 32'h0, 1'b0, 1'b0, 32'h0, "t2_wr5");
    txn(1, 1'b0, 9'd5, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "t2_rd5");

    // out-of-range on DEPTH=500
    txn(2, 1'b1, 9'd499, 32'h77, 3, 32'h0, 1'b0, 1'b0, 32'h0, "t3_wr499");
    txn(2, 1'b1, 9'd0, 32'hCC, 3, 32'h0, 1'b0, 1'b0, 32'h0, "t3_wr0");
    txn(2, 1'b0, 9'd499, 32'h0, 3, 32'h77, 1'b0, 1'b0, 32'h0, "t3_rd499a");
    txn(2, 1'b1, 9'd510, 32'h1, 3, 32'h77, 1'b1, 1'b0, 32'h0, "t3_wr510");
    txn(2, 1'b0, 9'd510, 32'h0, 3, 32'h0, 1'b1, 1'b0, 32'h0, "t3_rd510");
    txn(2, 1'b0, 9'd499, 32'h0, 3, 32'h77, 1'b0, 1'b0, 32'h0, "t3_rd499b");
    txn(2, 1'b0, 9'd0, 32'h0, 3, 32'hCC, 1'b0, 1'b0, 32'h0, "t3_rd0");

    // reset mid-WAIT discards the write
    txn(0, 1'b1, 9'd7, 32'h11, 3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "t4_wr7");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'd7; wdata[0] = 32'h22;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2 clr = 1'b1;
    #1;
    check("t4 clr_rdata", rdata[0], 32'h0);
    check("t4 clr_busy", 32'(busy[0]), 32'd0);
    check("t4 clr_ack", 32'(ack[0]), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    check("t4 no_ack", 32'(acks), 32'd0);
    txn(0, 1'b0, 9'd7, 32'h0, 3, 32'h11, 1'b0, 1'b0, 32'h0, "t4_rd7");

    // req while busy is ignored
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'd5;
    @(posedge clk);
    @(negedge clk);
    addr[0] = 9'd7;
    @(negedge clk);
    req[0] = 1'b0;
    acks = 0;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[0]) begin
        acks++;
        seen = rdata[0];
      end
    end
    check("t5 one_ack", 32'(acks), 32'd1);
    check("t5 busy_rdata", seen, 32'hDEADBEEF);

    // req held through ack: back-to-back capture at the edge ending ack
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'd5;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!ack[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5 b2b_lat1", 32'(n), 32'd3);
    check("t5 b2b_rd1", rdata[0], 32'hDEADBEEF);
    addr[0] = 9'd7;
    @(negedge clk);
    req[0] = 1'b0;
    check("t5 b2b_busy", 32'(busy[0]), 32'd1);
    check("t5 b2b_ackdrop", 32'(ack[0]), 32'd0);
    n = 0;
    while (!ack[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5 b2b_lat2", 32'(n), 32'd3);
    check("t5 b2b_rd2", rdata[0], 32'h11);

    // rdata holds between reads
    txn(0, 1'b1, 9'd3, 32'hA5A5A5A5, 3, 32'h11, 1'b0, 1'b0, 32'h0, "t6_wr3");
    txn(0, 1'b1, 9'd4, 32'h5A5A5A5A, 3, 32'h11, 1'b0, 1'b0, 32'h0, "t6_wr4");
    txn(0, 1'b0, 9'd3, 32'h0, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, "t6_rd3");
    txn(0, 1'b0, 9'd4, 32'h0, 3, 32'h5A5A5A5A, 1'b0, 1'b1, 32'hA5A5A5A5, "t6_rd4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
